// File: rtl/global_types.sv
// Project-wide scalar type aliases shared across datapath blocks.
package global_types;

    typedef logic [31:0] logic32;

endpackage

// File: rtl/mem_arb_pkg.sv
// Types and default constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int MAX_IF_WAIT_DEF = 4;
    localparam int TIMEOUT_DEF     = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; a saturating wait counter forces a fetch grant after
// MAX_IF_WAIT consecutive data grants. Every access passes through IDLE, and a
// BUSY access that never sees mem_ready is aborted after TIMEOUT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
    import global_types::*;
#(
    parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_error
);

    localparam int WAIT_W = $clog2(MAX_IF_WAIT + 1);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic32            if_hold;
    logic32            dm_hold;

    logic   grant_any;
    owner_t winner;
    logic   timeout_hit;
    logic   if_done;
    logic   dm_done;

    // Pick the IDLE winner: data first unless fetch has waited long enough.
    always_comb begin
        grant_any = if_req | dm_req;
        winner    = OWNER_D;
        if (if_req && (!dm_req || wait_cnt == WAIT_W'(MAX_IF_WAIT))) begin
            winner = OWNER_I;
        end
    end

    // An abort counts as completion so the requester is never stuck stalled.
    assign timeout_hit = (state != IDLE) && !mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));
    assign if_done     = (state == BUSY_I) && (mem_ready || timeout_hit);
    assign dm_done     = (state == BUSY_D) && (mem_ready || timeout_hit);
    assign if_stall    = if_req & ~if_done;
    assign dm_stall    = dm_req & ~dm_done;

    // Read data bypasses the holding register in the completion cycle; stores never touch it.
    assign if_rdata = ((state == BUSY_I) && mem_ready) ? mem_rdata : if_hold;
    assign dm_rdata = ((state == BUSY_D) && mem_ready && !mem_we) ? mem_rdata : dm_hold;

    // Arbitration FSM with registered memory-side outputs, counters and read holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_hold   <= '0;
            dm_hold   <= '0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (!grant_any) begin
                        wait_cnt <= '0;
                    end else if (winner == OWNER_I) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (!if_req) begin
                            wait_cnt <= '0;
                        end else if (wait_cnt != WAIT_W'(MAX_IF_WAIT)) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        to_cnt  <= '0;
                        if (state == BUSY_I) begin
                            if_hold <= mem_rdata;
                        end else if (!mem_we) begin
                            dm_hold <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        to_cnt    <= '0;
                        bus_error <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, a latency-programmable memory responder, and directed scenarios with
// hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;
    localparam int MAXW    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        bus_error;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.MAX_IF_WAIT(MAXW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Memory responder: ready arrives on BUSY cycle number 'lat' (0 = never).
    logic [31:0] mem [logic [31:0]];
    int lat = 1;
    int bcnt = 0;
    always @(posedge clock) begin
        if (mem_req && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
        #1;
        if (!mem_req) bcnt = 0;
        else bcnt++;
        mem_ready = mem_req && (lat > 0) && (bcnt == lat);
        mem_rdata = mem_ready ? (mem.exists(mem_addr) ? mem[mem_addr] : 32'h0) : 32'hBAD0BAD0;
    end

    // Reference model: who owns the memory, which BUSY cycle we are in, how
    // many data grants fetch has sat through, and what each requester last read.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    int          m_busy_cycle = 0;
    int          m_starve = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_if_hold = '0;
    logic [31:0] m_dm_hold = '0;
    logic        m_err = 1'b0;
    bit          chk_en = 1'b0;

    always @(negedge clock) begin
        logic        abort;
        logic        fin_i;
        logic        fin_d;
        logic [31:0] e_if;
        logic [31:0] e_dm;
        abort = (m_owner != 0) && !mem_ready && (m_busy_cycle == TIMEOUT);
        fin_i = (m_owner == 1) && (mem_ready || abort);
        fin_d = (m_owner == 2) && (mem_ready || abort);
        e_if  = (m_owner == 1 && mem_ready) ? mem_rdata : m_if_hold;
        e_dm  = (m_owner == 2 && mem_ready && !m_we) ? mem_rdata : m_dm_hold;
        if (chk_en) begin
            chk("cyc_mem_req",   {31'b0, mem_req},   {31'b0, m_owner != 0});
            chk("cyc_mem_we",    {31'b0, mem_we},    {31'b0, m_we});
            chk("cyc_mem_addr",  mem_addr,           m_addr);
            chk("cyc_mem_wdata", mem_wdata,          m_wdata);
            chk("cyc_if_stall",  {31'b0, if_stall},  {31'b0, if_req && !fin_i});
            chk("cyc_dm_stall",  {31'b0, dm_stall},  {31'b0, dm_req && !fin_d});
            chk("cyc_if_rdata",  if_rdata,           e_if);
            chk("cyc_dm_rdata",  dm_rdata,           e_dm);
            chk("cyc_bus_error", {31'b0, bus_error}, {31'b0, m_err});
        end
        if (reset) begin
            m_owner = 0; m_busy_cycle = 0; m_starve = 0; m_we = 0; m_addr = 0;
            m_wdata = 0; m_if_hold = 0; m_dm_hold = 0; m_err = 0;
        end else if (m_owner == 0) begin
            if (if_req && (!dm_req || m_starve == MAXW)) begin
                m_owner = 1; m_busy_cycle = 1; m_we = 0; m_addr = if_addr; m_wdata = 0;
                m_starve = 0;
            end else if (dm_req) begin
                m_owner = 2; m_busy_cycle = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                m_starve = if_req ? ((m_starve < MAXW) ? m_starve + 1 : MAXW) : 0;
            end else begin
                m_starve = 0;
            end
        end else if (mem_ready) begin
            if (m_owner == 1) m_if_hold = mem_rdata;
            else if (!m_we) m_dm_hold = mem_rdata;
            m_owner = 0;
        end else if (abort) begin
            m_err = 1'b1;
            m_owner = 0;
        end else begin
            m_busy_cycle++;
        end
    end

    // Grant monitor: address presented at each rising edge of mem_req.
    logic [31:0] grants[$];
    bit rec_en = 1'b0;
    logic prev_req = 1'b0;
    always @(negedge clock) begin
        if (rec_en && mem_req && !prev_req) grants.push_back(mem_addr);
        prev_req = mem_req;
    end

    task automatic run_if(input logic [31:0] addr, output int stalls, output logic [31:0] rd);
        if_req = 1'b1; if_addr = addr; stalls = 0; rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!if_stall) begin
                rd = if_rdata;
                break;
            end
            stalls++;
            if (i == 99) begin
                checks++; failures++;
                $display("FAIL if_wait_bound actual=stalled required=done addr=%h", addr);
            end
        end
        @(posedge clock); #2;
        if_req = 1'b0;
    endtask

    task automatic run_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit keep, output int stalls, output logic [31:0] rd);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; stalls = 0; rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!dm_stall) begin
                rd = dm_rdata;
                break;
            end
            stalls++;
            if (i == 99) begin
                checks++; failures++;
                $display("FAIL dm_wait_bound actual=stalled required=done addr=%h", addr);
            end
        end
        @(posedge clock); #2;
        if (!keep) dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          st_i;
        int          st_d;
        logic [31:0] rd;
        logic [31:0] rd_i;
        logic [31:0] rd_d;
        logic [31:0] exp_g [7];

        mem[32'h100] = 32'h2008000A;
        mem[32'h040] = 32'h11223344;
        mem[32'h200] = 32'h00000013;

        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clock);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clock); #2;

        // Fetch only
        lat = 1;
        run_if(32'h100, st, rd);
        chk("fetch_stall_cycles", 32'(st), 32'd1);
        chk("fetch_rdata", rd, 32'h2008000A);
        chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
        chk("fetch_rdata_held", if_rdata, 32'h2008000A);

        // Simultaneous fetch and data read: data served first
        fork
            run_dm(1'b0, 32'h40, 32'h0, 1'b0, st_d, rd_d);
            run_if(32'h200, st_i, rd_i);
        join
        chk("simul_dm_stalls", 32'(st_d), 32'd1);
        chk("simul_if_stalls", 32'(st_i), 32'd3);
        chk("simul_dm_rdata", rd_d, 32'h11223344);
        chk("simul_if_rdata", rd_i, 32'h00000013);

        // Starvation: continuous stores with fetch pending
        exp_g = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h100, 32'h310, 32'h314};
        grants.delete();
        rec_en = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    run_dm(1'b1, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k), k < 5, st_d, rd_d);
            end
            run_if(32'h100, st_i, rd_i);
        join
        rec_en = 1'b0;
        chk("starve_grant_count", 32'(grants.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            chk("starve_grant_addr", (i < grants.size()) ? grants[i] : 32'hFFFFFFFF, exp_g[i]);
        chk("starve_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        chk("starve_fetch_rdata", rd_i, 32'h2008000A);

        // Write then read with 3-cycle memory latency
        lat = 3;
        run_dm(1'b1, 32'h80, 32'hDEADBEEF, 1'b0, st, rd);
        chk("wr_stall_cycles", 32'(st), 32'd3);
        chk("wr_mem_content", mem.exists(32'h80) ? mem[32'h80] : 32'h0, 32'hDEADBEEF);
        chk("wr_dm_rdata_kept", dm_rdata, 32'h11223344);
        run_dm(1'b0, 32'h80, 32'h0, 1'b0, st, rd);
        chk("rd_stall_cycles", 32'(st), 32'd3);
        chk("rd_dm_rdata", rd, 32'hDEADBEEF);

        // Timeout: memory never ready
        lat = 0;
        run_dm(1'b0, 32'h44, 32'h0, 1'b0, st, rd);
        chk("to_stall_cycles", 32'(st), 32'd16);
        chk("to_dm_rdata", rd, 32'hDEADBEEF);
        chk("to_bus_error", {31'b0, bus_error}, 32'd1);
        chk("to_mem_req", {31'b0, mem_req}, 32'd0);
        lat = 1;
        run_dm(1'b0, 32'h40, 32'h0, 1'b0, st, rd);
        chk("to_after_rdata", rd, 32'h11223344);
        chk("to_sticky", {31'b0, bus_error}, 32'd1);

        // Reset in the middle of a data access
        lat = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48;
        repeat (3) @(posedge clock);
        #2;
        chk("mid_busy", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        dm_req = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_bus_error", {31'b0, bus_error}, 32'd0);
        chk("mid_rst_dm_rdata", dm_rdata, 32'd0);
        chk("mid_rst_if_rdata", if_rdata, 32'd0);
        chk("mid_rst_dm_stall", {31'b0, dm_stall}, 32'd0);
        lat = 1;
        run_if(32'h100, st, rd);
        chk("post_rst_fetch_stalls", 32'(st), 32'd1);
        chk("post_rst_fetch_rdata", rd, 32'h2008000A);

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction fetch and data memory stages.
- Serialises requests through a small FSM and drives per-requester stall signals back to the pipeline control.
- Data accesses win by default; a starvation counter guarantees forward progress for fetch.
- Sits between the datapath's pc / alu_out / dmem_wd / dmem_we signals and the external memory.

Parameters:
- MAX_IF_WAIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced to win.
- TIMEOUT, 16: BUSY cycles without mem_ready before the access is aborted.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request, held until if_stall low.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetch read data.
- if_stall  out  1  fetch not complete this cycle.
- dm_req  in  1  data request, held until dm_stall low.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data.
- dm_stall  out  1  data access not complete this cycle.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory completes the current access this cycle.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_wdata, if_rdata/dm_rdata holding registers, wait counter, timeout counter and bus_error all 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant:
  - If any req is high, the next state is BUSY_D or BUSY_I.
  - Default priority is data over fetch.
  - If if_req is high and wait_cnt == MAX_IF_WAIT, fetch wins.
- At the grant edge, the winner's addr, we and wdata are latched into the mem_* registers. Fetch latches mem_we = 0 and mem_wdata = 0.
- mem_req = 1 exactly while in BUSY_I or BUSY_D. Registered outputs stay stable for the whole access.
- Completion cycle: BUSY_x with mem_ready = 1.
  - Next state is IDLE.
  - The timeout counter clears.
  - On a read, x_rdata holding register <= mem_rdata.
- x_rdata is combinational:
  - equals mem_rdata in the completion cycle;
  - otherwise equals the holding register.
  - Writes never change dm_rdata.
- x_stall = x_req AND NOT (state == BUSY_x AND mem_ready).
  - The stall drops in the completion cycle, so the pipeline captures data at that edge.
- Minimum latency is 2 cycles per access: the IDLE grant cycle plus one BUSY cycle. No back-to-back issue from BUSY; every access passes through IDLE.
- wait_cnt:
  - increments, saturating at MAX_IF_WAIT, on each data grant while if_req = 1;
  - clears on a fetch grant, or in IDLE when if_req = 0.
- Timeout:
  - The BUSY cycle counter reaching TIMEOUT - 1 without mem_ready aborts the access.
  - Next state is IDLE and bus_error <= 1 (sticky until reset).
  - The holding register is unchanged.
  - The requester's stall drops for that abort cycle, treated as a completion.
- A requester dropping req mid-access does not abort it. The memory access completes, the result is discarded for stall purposes, and read data is still latched.
- Reset mid-access: at the next edge, state = IDLE and mem_req = 0; no completion is reported.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D};
  - owner_t enum {OWNER_I, OWNER_D};
  - default constants for MAX_IF_WAIT and TIMEOUT.
- Reuse logic32 from global_types.
- No sub-module: the FSM, the two counters and the output muxing stay in one module.

Test Plan:
- Fetch only:
  - Stimulus: if_req = 1, if_addr = 0x100, mem_ready high on the first BUSY cycle, mem_rdata = 0x2008000A.
  - Response: if_stall high 1 cycle then low, if_rdata = 0x2008000A, mem_we = 0.
- Simultaneous requests:
  - Stimulus: if_req and dm_req (read 0x40) both high from cycle 0.
  - Response: data served first; if_stall stays high until after the data access completes; fetch is served next.
- Starvation:
  - Stimulus: dm_req held high continuously with back-to-back stores, if_req high.
  - Response: after 4 data grants the 5th grant goes to fetch; wait_cnt returns to 0.
- Write then read:
  - Stimulus: store 0xDEADBEEF to 0x80, then load 0x80, with a model memory delaying ready by 3 cycles.
  - Response: mem_we/mem_addr/mem_wdata stable for all 3 BUSY cycles; dm_rdata = 0xDEADBEEF.
- Timeout:
  - Stimulus: dm_req with mem_ready held 0.
  - Response: after 16 BUSY cycles, the FSM returns to IDLE, bus_error = 1 and stays set, dm_rdata is unchanged, and dm_stall drops.
- Reset mid-access:
  - Stimulus: assert reset during BUSY_D.
  - Response: mem_req = 0 at the next edge; all outputs equal their reset values; a request after reset is served normally.
